// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 codes, the FSM state type and the funct3 legality check.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   // Stores only know B/H/W; loads add the two unsigned variants.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return (f3 > F3_W);
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data memory (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for one access: write mask, replicated store data,
// extended load data and the misalignment flag.
// Build option DMEM_MISALIGN_CHECK_EN: flag misaligned H/W accesses
// instead of silently aligning them.
module dmem_lane_align (
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_sh,
   output logic [31:0] ld_data,
   output logic        misalign
);

   logic [1:0]  off;
   logic [15:0] shifted;

   // Pick the effective lane offset, then build mask/data for the access size.
   always_comb begin
      misalign = 1'b0;
      off      = addr_lo;
`ifdef DMEM_MISALIGN_CHECK_EN
      case (funct3[1:0])
         2'b01:   misalign = addr_lo[0];
         2'b10:   misalign = |addr_lo;
         default: misalign = 1'b0;
      endcase
`else
      case (funct3[1:0])
         2'b01:   off = {addr_lo[1], 1'b0};
         2'b10:   off = 2'b00;
         default: off = addr_lo;
      endcase
`endif
      shifted = 16'(rword >> {off, 3'b000});
      case (funct3[1:0])
         2'b00: begin
            wmask    = 4'b0001 << off;
            wdata_sh = {4{wdata[7:0]}};
            ld_data  = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            wmask    = 4'b0011 << off;
            wdata_sh = {2{wdata[15:0]}};
            ld_data  = funct3[2] ? {16'b0, shifted} : {{16{shifted[15]}}, shifted};
         end
         default: begin
            wmask    = 4'b1111;
            wdata_sh = wdata;
            ld_data  = rword;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY from accept
// to response, word RAM with byte-lane writes.
// Build option DMEM_MISALIGN_CHECK_EN (see dmem_lane_align).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t   state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          in_idle, accept, exec, err;
   logic          op_we;
   logic [2:0]    op_f3;
   logic [AW+1:0] op_addr;
   logic [31:0]   op_wdata, rword, wdata_sh, ld_data;
   logic [3:0]    wmask;
   logic          misalign;

   assign in_idle = (state_q == IDLE);
   assign accept  = bus.req_valid && in_idle;

   // With LATENCY 1 the execute edge is the accept edge, so the operands
   // come straight from the bus while idle and from the latch otherwise.
   assign op_we    = in_idle ? bus.req_we              : we_q;
   assign op_f3    = in_idle ? bus.req_funct3          : f3_q;
   assign op_addr  = in_idle ? bus.req_addr[AW+1:0]    : addr_q;
   assign op_wdata = in_idle ? bus.req_wdata           : wdata_q;

   assign rword = mem[op_addr[AW+1:2]];
   assign err   = f3_illegal(op_we, op_f3) || misalign;

   dmem_lane_align u_align (
      .funct3   (op_f3),
      .addr_lo  (op_addr[1:0]),
      .wdata    (op_wdata),
      .rword    (rword),
      .wmask    (wmask),
      .wdata_sh (wdata_sh),
      .ld_data  (ld_data),
      .misalign (misalign)
   );

   // Next-state, latch and response capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      exec        = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            we_d    = bus.req_we;
            f3_d    = bus.req_funct3;
            addr_d  = bus.req_addr[AW+1:0];
            wdata_d = bus.req_wdata;
            cnt_d   = 4'(LATENCY - 1);
            if (LATENCY == 1) begin
               state_d = RESP;
               exec    = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = RESP;
            exec    = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP: if (bus.rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (exec) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = err;
         rsp_rdata_d = (err || op_we) ? 32'd0 : ld_data;
      end
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         f3_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Store commit on the execute edge; RAM is never reset.
   always_ff @(posedge clk) begin
      if (exec && op_we && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[op_addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = in_idle;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
